// File: rtl/avalon_uart_pkg.sv
// Shared types and constants for the UART transmit port and its FIFO.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   uart_state_t : serialiser FSM states (IDLE, START, DATA, STOP)
//   DATA_BITS    : payload bits per frame
//   FRAME_BITS   : total bits per 8N1 frame (start + data + stop)
package avalon_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = DATA_BITS + 2;

endpackage

// File: rtl/avalon_sync_fifo.sv
// Small synchronous FIFO holding bytes queued for serialisation.
// Latency: a push is visible at pop_data on the edge after it is written (no bypass).
// Backpressure: a push while full is dropped unless a pop happens in the same cycle.
//
// Ports:
//   CLK, RST            : clock and synchronous active-high reset
//   push, push_data     : write request and data
//   pop                 : read request; pop_data is the current head (combinational)
//   count, full, empty  : occupancy status, all decoded from registers
module avalon_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_do_pop;
    logic w_do_push;

    assign full  = (r_count == FULL_CNT);
    assign empty = (r_count == '0);
    assign count = r_count;

    assign pop_data = r_mem[r_rd_ptr];

    // The full check uses the pre-edge count, but a pop in the same cycle
    // frees the head slot, so a push into a full FIFO still succeeds then.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge CLK) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/avalon_uart_tx_port.sv
// CPU output port: queues byte writes and serialises them as 8N1 UART frames.
// Latency: write at edge N into an empty idle port drives the start bit after edge N+1.
// Backpressure: none to the core; fifo_full is polled, and a write while full is dropped and flagged.
//
// Ports:
//   CLK       : system clock, all state on the rising edge
//   RST       : synchronous active-high reset (aborts any frame in flight)
//   wr_en     : one-cycle write strobe from the output-bus decode
//   wr_data   : byte to transmit, sampled with wr_en
//   tx        : registered serial output, idle high
//   fifo_full : FIFO holds DEPTH entries (core EF0)
//   tx_idle   : serialiser idle and nothing queued (core EF1)
//   overflow  : sticky, a write was dropped because the FIFO was full
module avalon_uart_tx_port
    import avalon_uart_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int CLK_DIV = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       tx,
    output logic       fifo_full,
    output logic       tx_idle,
    output logic       overflow
);

    localparam int BW = $clog2(CLK_DIV);
    localparam int IW = $clog2(DATA_BITS);
    localparam int CW = $clog2(DEPTH) + 1;

    localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
    localparam logic [IW-1:0] BIT_LAST  = IW'(DATA_BITS - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

    // FIFO interface
    logic [7:0]    w_fifo_dat;
    logic [CW-1:0] w_fifo_count;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic          w_pop;

    // Serialiser state
    uart_state_t          r_state;
    uart_state_t          w_state_nxt;
    logic [BW-1:0]        r_baud;
    logic [BW-1:0]        w_baud_nxt;
    logic [IW-1:0]        r_bit;
    logic [IW-1:0]        w_bit_nxt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic                 r_tx;
    logic                 w_tx_nxt;
    logic                 r_overflow;
    logic                 w_baud_done;

    avalon_sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (w_pop),
        .pop_data  (w_fifo_dat),
        .count     (w_fifo_count),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

    assign w_baud_done = (r_baud == BAUD_LAST);

    // ------------------------------------------------------------------
    // FSM state and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_tx    <= w_tx_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and datapath updates.
    // tx is computed one cycle ahead and registered, so every bit period
    // starts exactly on the edge that enters it and the pin never glitches.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_tx_nxt    = r_tx;
        w_pop       = 1'b0;

        case (r_state)
            IDLE: begin
                w_tx_nxt = 1'b1;
                if (!w_fifo_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_fifo_dat;
                    w_tx_nxt    = 1'b0;
                    w_baud_nxt  = '0;
                    w_state_nxt = START;
                end
            end

            START: begin
                if (w_baud_done) begin
                    w_tx_nxt    = r_shift[0];
                    w_bit_nxt   = '0;
                    w_baud_nxt  = '0;
                    w_state_nxt = DATA;
                end else begin
                    w_baud_nxt = r_baud + 1'b1;
                end
            end

            DATA: begin
                if (w_baud_done) begin
                    w_baud_nxt = '0;
                    if (r_bit == BIT_LAST) begin
                        w_tx_nxt    = 1'b1;
                        w_state_nxt = STOP;
                    end else begin
                        // Shift right so the next bit to send is always at [0];
                        // [1] is what lands there after this shift.
                        w_bit_nxt   = r_bit + 1'b1;
                        w_shift_nxt = {1'b0, r_shift[DATA_BITS-1:1]};
                        w_tx_nxt    = r_shift[1];
                    end
                end else begin
                    w_baud_nxt = r_baud + 1'b1;
                end
            end

            STOP: begin
                if (w_baud_done) begin
                    w_baud_nxt  = '0;
                    w_state_nxt = IDLE;
                end else begin
                    w_baud_nxt = r_baud + 1'b1;
                end
            end

            default: begin
                w_tx_nxt    = 1'b1;
                w_baud_nxt  = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Sticky overflow: only a write that the FIFO really drops counts.
    // A write landing on the same edge as a pop is accepted.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_overflow <= 1'b0;
        end else if (wr_en && w_fifo_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    assign tx        = r_tx;
    assign overflow  = r_overflow;
    assign fifo_full = (w_fifo_count == FULL_CNT);
    assign tx_idle   = (r_state == IDLE) && w_fifo_empty;

endmodule

// File: tb/tb_avalon_uart_tx_port.sv
module tb_avalon_uart_tx_port;
    import avalon_uart_pkg::*;

    localparam int CDIV = 4;
    localparam int DEP  = 4;
    localparam int FRAME_CYC = FRAME_BITS * CDIV;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       tx;
    logic       fifo_full;
    logic       tx_idle;
    logic       overflow;

    int n_vec = 0;
    int n_err = 0;

    // Decoded frames: {stop_bit, data_byte}
    logic [8:0] rxq [$];

    always #5 CLK = ~CLK;

    avalon_uart_tx_port #(
        .DEPTH   (DEP),
        .CLK_DIV (CDIV)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .tx        (tx),
        .fifo_full (fifo_full),
        .tx_idle   (tx_idle),
        .overflow  (overflow)
    );

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic pulse_reset;
        RST = 1'b1;
        tick();
        RST = 1'b0;
    endtask

    task automatic wait_rx(input string tag, input int n, input int budget);
        for (int i = 0; i < budget && rxq.size() < n; i++) tick();
        check(tag, rxq.size(), n);
    endtask

    task automatic expect_rx(input string tag, input logic [7:0] e);
        logic [8:0] got;
        got = 9'h000;
        if (rxq.size() != 0) got = rxq.pop_front();
        check(tag, got, {1'b1, e});
    endtask

    // Serial line monitor: samples each bit in the middle of its period.
    initial begin : monitor
        logic [7:0] b;
        logic       s;
        forever begin
            tick();
            if (tx === 1'b0) begin
                repeat (CDIV + CDIV / 2) @(posedge CLK);
                #1;
                b[0] = tx;
                for (int k = 1; k < DATA_BITS; k++) begin
                    repeat (CDIV) @(posedge CLK);
                    #1;
                    b[k] = tx;
                end
                repeat (CDIV) @(posedge CLK);
                #1;
                s = tx;
                rxq.push_back({s, b});
                repeat (CDIV / 2) @(posedge CLK);
                #1;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin : stim
        logic [7:0] pat;
        logic       exp_tx;
        logic [7:0] wdat [9];

        // ---------------- reset ----------------
        RST = 1'b1;
        repeat (3) tick();
        check("rst_tx", tx, 1'b1);
        check("rst_full", fifo_full, 1'b0);
        check("rst_idle", tx_idle, 1'b1);
        check("rst_ovf", overflow, 1'b0);
        RST = 1'b0;
        tick();

        // ---------------- single byte, cycle-exact ----------------
        pat = 8'hA5;
        write(pat);                       // edge N
        check("sb_tx_n", tx, 1'b1);
        check("sb_idle_n", tx_idle, 1'b0);
        for (int i = 1; i <= FRAME_CYC; i++) begin
            tick();                       // edge N+i
            if (i <= CDIV) exp_tx = 1'b0;
            else if (i <= CDIV * (DATA_BITS + 1)) exp_tx = pat[(i - CDIV - 1) / CDIV];
            else exp_tx = 1'b1;
            check($sformatf("sb_tx_%0d", i), tx, exp_tx);
        end
        check("sb_idle_n40", tx_idle, 1'b0);
        tick();                           // edge N+41
        check("sb_idle_n41", tx_idle, 1'b1);
        check("sb_tx_n41", tx, 1'b1);
        wait_rx("sb_rxcnt", 1, 20);
        expect_rx("sb_rx", 8'hA5);

        // ---------------- simultaneous push/pop at full ----------------
        pulse_reset();
        check("pp_ovf_rst", overflow, 1'b0);
        write(8'h11);                     // E1
        write(8'h22);                     // E2: 11 popped, 22 pushed
        write(8'h33);
        write(8'h44);                     // E4
        check("pp_full_e4", fifo_full, 1'b0);
        write(8'h55);                     // E5
        check("pp_full_e5", fifo_full, 1'b1);
        repeat (37) tick();               // E42: FSM back in IDLE
        check("pp_full_e42", fifo_full, 1'b1);
        check("pp_idle_e42", tx_idle, 1'b0);
        write(8'h77);                     // E43: pop 22 and push 77
        check("pp_full_e43", fifo_full, 1'b1);
        check("pp_ovf_e43", overflow, 1'b0);
        wait_rx("pp_rxcnt", 6, 6 * (FRAME_CYC + 5));
        expect_rx("pp_rx0", 8'h11);
        expect_rx("pp_rx1", 8'h22);
        expect_rx("pp_rx2", 8'h33);
        expect_rx("pp_rx3", 8'h44);
        expect_rx("pp_rx4", 8'h55);
        expect_rx("pp_rx5", 8'h77);
        check("pp_ovf_end", overflow, 1'b0);

        // ---------------- fill and overflow ----------------
        repeat (10) tick();
        pulse_reset();
        for (int k = 1; k <= 4; k++) write(8'(k));   // E1..E4
        check("of_full_e4", fifo_full, 1'b0);
        write(8'h05);                     // E5
        check("of_full_e5", fifo_full, 1'b1);
        check("of_ovf_e5", overflow, 1'b0);
        write(8'h06);                     // E6: dropped
        check("of_full_e6", fifo_full, 1'b1);
        check("of_ovf_e6", overflow, 1'b1);
        repeat (36) tick();               // E42: between frames
        check("of_idle_gap", tx_idle, 1'b0);
        wait_rx("of_rxcnt", 5, 5 * (FRAME_CYC + 5));
        expect_rx("of_rx0", 8'h01);
        expect_rx("of_rx1", 8'h02);
        expect_rx("of_rx2", 8'h03);
        expect_rx("of_rx3", 8'h04);
        expect_rx("of_rx4", 8'h05);
        repeat (FRAME_CYC + 20) tick();
        check("of_no_06", rxq.size(), 0);
        check("of_idle_end", tx_idle, 1'b1);
        check("of_ovf_sticky", overflow, 1'b1);

        // ---------------- reset mid-frame ----------------
        pulse_reset();
        check("rm_ovf_clr", overflow, 1'b0);
        write(8'hFF);                     // edge N
        repeat (17) tick();               // edge N+17: DATA bit 3
        check("rm_tx_bit3", tx, 1'b1);
        check("rm_idle_bit3", tx_idle, 1'b0);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("rm_tx", tx, 1'b1);
        check("rm_idle", tx_idle, 1'b1);
        check("rm_full", fifo_full, 1'b0);
        repeat (FRAME_CYC) tick();
        check("rm_tx_quiet", tx, 1'b1);
        rxq.delete();                     // discard the aborted frame's decode
        write(8'h3C);
        wait_rx("rm_rxcnt", 1, FRAME_CYC + 10);
        expect_rx("rm_rx", 8'h3C);

        // ---------------- pointer wrap-around ----------------
        repeat (10) tick();
        pulse_reset();
        wdat = '{8'h5A, 8'hC3, 8'h0F, 8'hF0, 8'h81, 8'h7E, 8'h33, 8'hCC, 8'h96};
        for (int k = 0; k < 9; k++) begin
            write(wdat[k]);
            repeat (FRAME_CYC + 4) tick();
        end
        wait_rx("wr_rxcnt", 9, FRAME_CYC + 10);
        for (int k = 0; k < 9; k++) begin
            expect_rx($sformatf("wr_rx%0d", k), wdat[k]);
        end
        check("wr_idle_end", tx_idle, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
